// File: rtl/kbd_uart_rx.sv
// 8N1 serial receiver feeding the CPU keyboard register and FGI flag.
// The line is sampled mid-bit; a low stop bit parks the receiver until the line returns high.
module kbd_uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       rx,
   input  logic       inp_ack,
   input  logic       err_clr,
   output logic [7:0] keyboard,
   output logic       en_inp,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   cnt_r;
   logic [2:0]      idx_r;
   logic [7:0]      shift_r;
   logic            rx_meta_r;
   logic            rx_sync_r;

   logic            stop_tick_s;
   logic            frame_ok_s;
   logic            frame_bad_s;
   logic            accept_s;
   logic            lost_s;

   // Stop-bit decision and what happens to a completed character.
   always_comb begin
      stop_tick_s = 1'b0;
      if (state_r == STOP && cnt_r == CNT_LAST) begin
         stop_tick_s = 1'b1;
      end else begin
         stop_tick_s = 1'b0;
      end
      frame_ok_s  = stop_tick_s & rx_sync_r;
      frame_bad_s = stop_tick_s & ~rx_sync_r;
      accept_s    = frame_ok_s & (~en_inp | inp_ack);
      lost_s      = frame_ok_s & en_inp & ~inp_ack;
   end

   // Synchroniser, receive FSM and the registered CPU-facing flags.
   always_ff @(posedge clkin) begin
      if (rst) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         idx_r     <= 3'd0;
         shift_r   <= 8'h00;
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         keyboard  <= 8'h00;
         en_inp    <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;

         case (state_r)
            IDLE: begin
               if (!rx_sync_r) begin
                  state_r <= START;
                  cnt_r   <= '0;
               end
            end
            START: begin
               // Re-check the start bit at its centre to reject glitches.
               if (cnt_r == CNT_HALF) begin
                  cnt_r <= '0;
                  idx_r <= 3'd0;
                  if (!rx_sync_r) begin
                     state_r <= DATA;
                  end else begin
                     state_r <= IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DATA: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r   <= '0;
                  shift_r <= {rx_sync_r, shift_r[7:1]};
                  if (idx_r == 3'd7) begin
                     state_r <= STOP;
                  end else begin
                     idx_r <= idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            STOP: begin
               if (cnt_r == CNT_LAST) begin
                  cnt_r <= '0;
                  if (rx_sync_r) begin
                     state_r <= IDLE;
                  end else begin
                     state_r <= BREAK;
                  end
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            BREAK: begin
               if (rx_sync_r) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase

         if (accept_s) begin
            keyboard <= shift_r;
            en_inp   <= 1'b1;
         end else if (inp_ack) begin
            en_inp <= 1'b0;
         end

         // Set events take priority over a simultaneous clear.
         if (frame_bad_s) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end

         if (lost_s) begin
            overrun <= 1'b1;
         end else if (err_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kbd_uart_rx.sv
// Directed bench for kbd_uart_rx at 16 clocks per bit; inputs change on the falling
// clock edge, outputs are sampled 1 ns after the rising edge.
module tb_kbd_uart_rx;

   logic       clkin;
   logic       rst;
   logic       rx;
   logic       inp_ack;
   logic       err_clr;
   logic [7:0] keyboard;
   logic       en_inp;
   logic       frame_err;
   logic       overrun;

   int checks;
   int failures;

   kbd_uart_rx #(.CLKS_PER_BIT(16)) dut (
      .clkin     (clkin),
      .rst       (rst),
      .rx        (rx),
      .inp_ack   (inp_ack),
      .err_clr   (err_clr),
      .keyboard  (keyboard),
      .en_inp    (en_inp),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clkin);
   endtask

   // Drives one 160-cycle frame; lat is the rising-edge count at which en_inp first rose.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int lat);
      logic en0;
      int   b;
      en0 = en_inp;
      lat = -1;
      for (int c = 0; c < 160; c++) begin
         b = c / 16;
         if (b == 0) rx = 1'b0;
         else if (b < 9) rx = d[b-1];
         else rx = stop_bit;
         @(posedge clkin);
         #1;
         if (lat < 0 && en_inp && !en0) lat = c + 1;
         @(negedge clkin);
      end
   endtask

   task automatic pulse_ack;
      inp_ack = 1'b1;
      @(negedge clkin);
      inp_ack = 1'b0;
   endtask

   task automatic pulse_err_clr;
      err_clr = 1'b1;
      @(negedge clkin);
      err_clr = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; rx = 1'b1; inp_ack = 1'b1; err_clr = 1'b1;
      wait_cycles(3);
      checks++; if (keyboard !== 8'h00) begin failures++; $display("FAIL reset_keyboard got=%h exp=00", keyboard); end
      checks++; if (en_inp !== 1'b0) begin failures++; $display("FAIL reset_en_inp got=%b exp=0", en_inp); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      rst = 1'b0; inp_ack = 1'b0; err_clr = 1'b0;
      wait_cycles(5);
   endtask

   task automatic test_single;
      int lat;
      send_frame(8'hA5, 1'b1, lat);
      checks++; if (lat < 152 || lat > 155) begin failures++; $display("FAIL a5_latency got=%0d exp=152..155", lat); end
      checks++; if (keyboard !== 8'hA5) begin failures++; $display("FAIL a5_keyboard got=%h exp=a5", keyboard); end
      checks++; if (en_inp !== 1'b1) begin failures++; $display("FAIL a5_en_inp got=%b exp=1", en_inp); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL a5_frame_err got=%b exp=0", frame_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL a5_overrun got=%b exp=0", overrun); end
   endtask

   task automatic test_ack;
      int lat;
      pulse_ack();
      send_frame(8'h3C, 1'b1, lat);
      checks++; if (keyboard !== 8'h3C || en_inp !== 1'b1) begin failures++; $display("FAIL ack_first got=%h/%b exp=3c/1", keyboard, en_inp); end
      inp_ack = 1'b1;
      @(posedge clkin);
      #1;
      checks++; if (en_inp !== 1'b0) begin failures++; $display("FAIL ack_clear got=%b exp=0", en_inp); end
      checks++; if (keyboard !== 8'h3C) begin failures++; $display("FAIL ack_hold got=%h exp=3c", keyboard); end
      @(negedge clkin);
      inp_ack = 1'b0;
      send_frame(8'hC3, 1'b1, lat);
      checks++; if (keyboard !== 8'hC3 || en_inp !== 1'b1) begin failures++; $display("FAIL ack_second got=%h/%b exp=c3/1", keyboard, en_inp); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ack_overrun got=%b exp=0", overrun); end
   endtask

   task automatic test_overrun;
      int lat;
      pulse_ack();
      send_frame(8'h11, 1'b1, lat);
      send_frame(8'h22, 1'b1, lat);
      checks++; if (keyboard !== 8'h11) begin failures++; $display("FAIL ovr_keyboard got=%h exp=11", keyboard); end
      checks++; if (en_inp !== 1'b1) begin failures++; $display("FAIL ovr_en_inp got=%b exp=1", en_inp); end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
      pulse_err_clr();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
      checks++; if (keyboard !== 8'h11) begin failures++; $display("FAIL ovr_keep got=%h exp=11", keyboard); end
   endtask

   task automatic test_glitch;
      int lat;
      pulse_ack();
      rx = 1'b0;
      wait_cycles(4);
      rx = 1'b1;
      wait_cycles(30);
      checks++; if (en_inp !== 1'b0) begin failures++; $display("FAIL glitch_en_inp got=%b exp=0", en_inp); end
      checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL glitch_flags got=%b%b exp=00", frame_err, overrun); end
      send_frame(8'h5A, 1'b1, lat);
      checks++; if (keyboard !== 8'h5A || en_inp !== 1'b1) begin failures++; $display("FAIL glitch_next got=%h/%b exp=5a/1", keyboard, en_inp); end
   endtask

   task automatic test_frame_err;
      int lat;
      pulse_ack();
      send_frame(8'h77, 1'b0, lat);
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
      checks++; if (en_inp !== 1'b0 || keyboard !== 8'h5A) begin failures++; $display("FAIL ferr_unchanged got=%h/%b exp=5a/0", keyboard, en_inp); end
      wait_cycles(40);
      rx = 1'b1;
      wait_cycles(200);
      checks++; if (en_inp !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL ferr_break got=%b/%b exp=0/0", en_inp, overrun); end
      pulse_err_clr();
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
      send_frame(8'h55, 1'b1, lat);
      checks++; if (keyboard !== 8'h55 || en_inp !== 1'b1 || frame_err !== 1'b0) begin failures++; $display("FAIL ferr_next got=%h/%b/%b exp=55/1/0", keyboard, en_inp, frame_err); end
   endtask

   task automatic test_mid_reset;
      int         lat;
      logic [7:0] d;
      d = 8'hEE;
      for (int c = 0; c < 88; c++) begin
         if (c < 16) rx = 1'b0;
         else rx = d[c/16 - 1];
         @(negedge clkin);
      end
      rst = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      rx  = 1'b1;
      checks++; if (keyboard !== 8'h00 || en_inp !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=%h/%b exp=00/0", keyboard, en_inp); end
      wait_cycles(120);
      checks++; if (en_inp !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b%b%b exp=000", en_inp, frame_err, overrun); end
      send_frame(8'h81, 1'b1, lat);
      checks++; if (keyboard !== 8'h81 || en_inp !== 1'b1) begin failures++; $display("FAIL rst_mid_next got=%h/%b exp=81/1", keyboard, en_inp); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1; rx = 1'b1; inp_ack = 1'b0; err_clr = 1'b0;
      @(negedge clkin);
      test_reset();
      test_single();
      test_ack();
      test_overrun();
      test_glitch();
      test_frame_err();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kbd_uart_rx.md
KBD_UART_RX -- requirements
Module: kbd_uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clkin cycles per serial bit; it must be even and at least 8.
REQ-002 The block SHALL have port clkin, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port inp_ack, input, 1 bit: the CPU has consumed the character (clears the input flag).
REQ-006 The block SHALL have port err_clr, input, 1 bit: clears the sticky error flags.
REQ-007 The block SHALL have port keyboard, output, 8 bits: last accepted character, feeding the CPU keyboard input.
REQ-008 The block SHALL have port en_inp, output, 1 bit: input-ready flag (FGI), feeding the CPU en_inp input.
REQ-009 The block SHALL have port frame_err, output, 1 bit: sticky flag, set when a stop bit is sampled low.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a valid character is lost.

Function
REQ-011 rx SHALL pass through a 2-flop synchroniser, rx_s; all decisions use rx_s only.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, with one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-013 IDLE: when rx_s=0, the FSM SHALL go to START and clear the counter.
REQ-014 START: at counter = CLKS_PER_BIT/2-1, if rx_s=0 the FSM SHALL go to DATA with counter and index cleared; otherwise it SHALL return to IDLE as a glitch, with no flag change.
REQ-015 DATA: at counter = CLKS_PER_BIT-1, the FSM SHALL shift rx_s into an 8-bit shift register at bit 7 (shift right) and clear the counter.
REQ-016 DATA: after the 8th sample (index 7), the FSM SHALL go to STOP.
REQ-017 STOP: at counter = CLKS_PER_BIT-1, if rx_s=1 the frame SHALL be valid and the FSM SHALL go to IDLE.
REQ-018 STOP: at counter = CLKS_PER_BIT-1, if rx_s=0 the FSM SHALL set frame_err, leave keyboard and en_inp unchanged, and go to BREAK.
REQ-019 BREAK: the FSM SHALL stay until rx_s=1, then go to IDLE, so a held-low line never starts a new frame.
REQ-020 On a valid frame with en_inp=0 or inp_ack=1 in that cycle, the block SHALL load keyboard from the shift register and set en_inp=1 on the same edge.
REQ-021 On a valid frame with en_inp=1 and inp_ack=0, the block SHALL set overrun and leave keyboard and en_inp unchanged (the old character is kept).
REQ-022 When inp_ack=1 and no valid frame completes in that cycle, en_inp SHALL clear on the next edge; keyboard SHALL hold its value.
REQ-023 When err_clr=1, frame_err and overrun SHALL clear on the next edge; a set event in the same cycle wins.
REQ-024 keyboard SHALL change only on an accepted frame, so it is stable while en_inp=1.
REQ-025 Latency: en_inp SHALL rise 9.5 bit periods +3/-0 clkin cycles after the rx falling edge of the start bit.
REQ-026 All outputs SHALL be registered; no output depends combinationally on an input.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set FSM=IDLE, counter=0, index=0, shift register=0, both synchroniser flops=1, keyboard=8'h00, en_inp=0, frame_err=0 and overrun=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame, with no flag or keyboard update; after rst falls, the block SHALL wait for a fresh start bit.
REQ-029 The block SHALL ignore inp_ack and err_clr while rst=1.

Verification (CLKS_PER_BIT=16)
REQ-030 Bench SHALL cover: frame 0xA5, valid stop -> keyboard=8'hA5, en_inp=1 within 152..155 cycles of the start edge, frame_err=0, overrun=0.
REQ-031 Bench SHALL cover: 0x3C received, inp_ack pulse, then 0xC3 -> en_inp clears one cycle after ack, then keyboard=8'hC3 and en_inp=1, no overrun.
REQ-032 Bench SHALL cover: 0x11 then 0x22 with no ack -> keyboard=8'h11, overrun=1; err_clr -> overrun=0, keyboard still 8'h11.
REQ-033 Bench SHALL cover: a 4-cycle low glitch on rx -> FSM back in IDLE, no flags, en_inp=0.
REQ-034 Bench SHALL cover: frame with stop bit 0 and rx held low 40 cycles -> frame_err=1, en_inp unchanged, no new frame until rx returns high; a following 0x55 frame is then received correctly.
REQ-035 Bench SHALL cover: rst pulsed during data bit 4, then frame 0x81 -> only 0x81 appears, en_inp=1, keyboard=8'h81.
